// File: rtl/gecko_pkg.sv
// Shared constants and types for the gecko load/store path.
package gecko_pkg;

    localparam int unsigned GECKO_WORD_WIDTH       = 32;
    localparam int unsigned GECKO_BYTE_LANES       = GECKO_WORD_WIDTH / 8;
    localparam int unsigned GECKO_MEM_RESULT_DEPTH = 3;

    typedef logic [GECKO_WORD_WIDTH-1:0] gecko_word_t;
    typedef logic [GECKO_BYTE_LANES-1:0] gecko_lane_mask_t;

endpackage

// File: rtl/std_mem_intf.sv
// Valid/ready memory channel carrying a load/store request or a read result.
interface std_mem_intf;

    logic        valid;
    logic        ready;
    logic        read_enable;
    logic [3:0]  write_enable;
    logic [31:0] addr;
    logic [31:0] data;

    modport in (
        input  valid,
        input  read_enable,
        input  write_enable,
        input  addr,
        input  data,
        output ready
    );

    modport out (
        output valid,
        output read_enable,
        output write_enable,
        output addr,
        output data,
        input  ready
    );

endinterface

// File: rtl/std_fifo.sv
// First-word-fall-through FIFO of arbitrary depth; head data only moves on pop.
module std_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            wr_d = (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/gecko_mem_responder.sv
// Single-port word memory answering gecko_execute loads/stores, with a
// registered-ready result buffer feeding the load writeback path.
module gecko_mem_responder
    import gecko_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned RESULT_DEPTH = GECKO_MEM_RESULT_DEPTH  // must be >= 3
) (
    input logic       clk,
    input logic       rst,
    std_mem_intf.in   mem_request,
    std_mem_intf.out  mem_result
);

    localparam int unsigned Words = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = $clog2(RESULT_DEPTH + 1);

    gecko_word_t           mem_q [Words];
    gecko_word_t           rd_data_q;
    logic [ADDR_WIDTH-1:0] word;
    logic                  accept;
    logic                  inflight_q;
    logic                  run_q;
    logic [CntW-1:0]       count;
    logic [CntW:0]         occupancy;
    logic                  empty;
    logic                  pop;
    logic                  unused_addr;

    assign word        = mem_request.addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{mem_request.addr[31:ADDR_WIDTH+2], mem_request.addr[1:0]};

    // Ready looks only at registered state; run_q holds it low for the cycle after reset.
    always_comb begin
        occupancy         = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
        mem_request.ready = run_q && (occupancy < (CntW + 1)'(RESULT_DEPTH));
        accept            = mem_request.valid && mem_request.ready;
        pop               = mem_result.valid && mem_result.ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            inflight_q <= accept && mem_request.read_enable;
            run_q      <= 1'b1;
        end
    end

    // Memory contents survive reset; the non-blocking read gives read-first ordering.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (mem_request.read_enable) begin
                rd_data_q <= mem_q[word];
            end
            for (int i = 0; i < GECKO_BYTE_LANES; i++) begin
                if (mem_request.write_enable[i]) begin
                    mem_q[word][8*i +: 8] <= mem_request.data[8*i +: 8];
                end
            end
        end
    end

    std_fifo #(
        .WIDTH (GECKO_WORD_WIDTH),
        .DEPTH (RESULT_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rd_data_q),
        .pop       (pop),
        .pop_data  (mem_result.data),
        .empty     (empty),
        .count     (count)
    );

    assign mem_result.valid        = !empty;
    assign mem_result.read_enable  = 1'b0;
    assign mem_result.write_enable = '0;
    assign mem_result.addr         = '0;

endmodule

// File: tb/tb_gecko_mem_responder.sv
// Directed and randomized checks of gecko_mem_responder against a queue-based model.
module tb_gecko_mem_responder;
    import gecko_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = GECKO_MEM_RESULT_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_drv = 1'b0;
    always #5 clk = ~clk;

    std_mem_intf req_if ();
    std_mem_intf res_if ();

    gecko_mem_responder #(
        .ADDR_WIDTH   (AW),
        .RESULT_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_request (req_if),
        .mem_result  (res_if)
    );

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mdl_mem [1024];
    pend_t       pending [$];
    logic [31:0] observed [$];
    bit          mdl_run = 1'b0;
    bit          last_accept;
    logic        last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare outputs, then advance the model
    // exactly as the rising edge will.
    task automatic cycle(input bit v, input bit re, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] data, input bit rr);
        bit              exp_ready, exp_valid, acc;
        logic [AW-1:0]   w;
        @(negedge clk);
        rst                 = rst_drv;
        req_if.valid        = v;
        req_if.read_enable  = re;
        req_if.write_enable = we;
        req_if.addr         = addr;
        req_if.data         = data;
        res_if.ready        = rr;
        #1;
        exp_ready = mdl_run && (pending.size() < DEPTH);
        exp_valid = (pending.size() > 0) && (cyc - pending[0].acc_cyc >= 2);
        check("ready", {31'b0, req_if.ready}, {31'b0, exp_ready});
        check("valid", {31'b0, res_if.valid}, {31'b0, exp_valid});
        if (exp_valid && res_if.valid) check("data", res_if.data, pending[0].data);
        last_ready = req_if.ready;
        acc = v && exp_ready;
        last_accept = acc;
        if (!rst_drv) begin
            pending.delete();
            mdl_run = 1'b0;
        end else begin
            if (exp_valid && rr) begin
                observed.push_back(res_if.data);
                void'(pending.pop_front());
            end
            if (acc) begin
                w = addr[AW+1:2];
                if (re) pending.push_back('{mdl_mem[int'(w)], cyc});
                for (int i = 0; i < 4; i++)
                    if (we[i]) mdl_mem[int'(w)][8*i +: 8] = data[8*i +: 8];
            end
            mdl_run = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 32'h0, 32'h0, 1);
    endtask

    initial begin
        int idx;
        int drops;
        req_if.valid = 0; req_if.read_enable = 0; req_if.write_enable = 0;
        req_if.addr = 0; req_if.data = 0; res_if.ready = 0;

        rst_drv = 1'b0;
        idle(2);
        rst_drv = 1'b1;
        idle(2);

        // Full-word store then load; result two cycles after the load.
        observed.delete();
        cycle(1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 1);
        cycle(1, 1, 4'h0, 32'h10, 32'h0, 1);
        idle(4);
        check("rd_full_count", 32'(observed.size()), 32'd1);
        check("rd_full_data", observed[0], 32'hDEADBEEF);

        // Byte-lane merge, with low address bits ignored.
        observed.delete();
        cycle(1, 0, 4'hF, 32'h20, 32'h11223344, 1);
        cycle(1, 0, 4'b0101, 32'h22, 32'hAABBCCDD, 1);
        cycle(1, 1, 4'h0, 32'h20, 32'h0, 1);
        idle(4);
        check("lane_merge", observed[0], 32'h11BB33DD);

        // Read-first in a combined request, then store visible to the next load.
        observed.delete();
        cycle(1, 0, 4'hF, 32'h30, 32'h5, 1);
        cycle(1, 1, 4'hF, 32'h30, 32'h9, 1);
        cycle(1, 1, 4'h0, 32'h30, 32'h0, 1);
        idle(4);
        check("rw_old", observed[0], 32'h5);
        check("rw_new", observed[1], 32'h9);

        // Backpressure: three accepts fill the pipeline, head held stable.
        for (int i = 0; i < 4; i++) cycle(1, 0, 4'hF, 32'(i * 4), 32'hA0000000 + 32'(i), 1);
        observed.delete();
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(idx < 4, 1, 4'h0, 32'(idx * 4), 32'h0, 0);
            if (last_accept) idx++;
        end
        check("stall_accepts", 32'(idx), 32'd3);
        check("stall_ready", {31'b0, req_if.ready}, 32'd0);
        check("held_data", res_if.data, 32'hA0000000);
        for (int k = 0; k < 10; k++) begin
            cycle(idx < 4, 1, 4'h0, 32'(idx * 4), 32'h0, 1);
            if (last_accept) idx++;
        end
        idle(4);
        check("release_accepts", 32'(idx), 32'd4);
        check("release_count", 32'(observed.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("release_order", observed[i], 32'hA0000000 + 32'(i));

        // Initialise 16 words, then 100 back-to-back loads.
        for (int i = 0; i < 16; i++) cycle(1, 0, 4'hF, 32'(i * 4), $urandom, 1);
        observed.delete();
        drops = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1, 1, 4'h0, 32'((k % 16) * 4), 32'h0, 1);
            if (last_ready !== 1'b1) drops++;
        end
        idle(4);
        check("stream_drops", 32'(drops), 32'd0);
        check("stream_count", 32'(observed.size()), 32'd100);

        // Random mix over aliased addresses of the initialised words.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 15)) << 2);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  a, $urandom, $urandom_range(0, 3) != 0);
        end
        idle(6);

        // Reset with one read in flight and one buffered.
        cycle(1, 0, 4'hF, 32'h44, 32'hCAFEF00D, 1);
        cycle(1, 1, 4'h0, 32'h0, 32'h0, 0);
        cycle(1, 1, 4'h0, 32'h4, 32'h0, 0);
        observed.delete();
        rst_drv = 1'b0;
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1);
        rst_drv = 1'b1;
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1);
        check("post_reset_ready_low", {31'b0, last_ready}, 32'd0);
        cycle(1, 1, 4'h0, 32'h44, 32'h0, 1);
        check("post_reset_ready_high", {31'b0, last_ready}, 32'd1);
        idle(4);
        check("post_reset_count", 32'(observed.size()), 32'd1);
        check("post_reset_data", observed[0], 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/gecko_mem_responder.md
GECKO_MEM_RESPONDER -- requirements
Module: gecko_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits (memory depth 2**ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter RESULT_DEPTH, default 3, result buffer entries; values below 3 are illegal.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port mem_request  std_mem_intf.in  valid/ready, read_enable 1, write_enable 4, addr 32, data 32  load/store requests from gecko_execute.
REQ-006 SHALL have port mem_result  std_mem_intf.out  valid/ready, data 32  read data returned to the load writeback path.

Function
REQ-007 SHALL accept a request in a cycle where mem_request.valid and mem_request.ready are both 1; no other cycle changes memory or queues a result.
REQ-008 SHALL index memory with word = addr[ADDR_WIDTH+1:2]; addr[1:0] and higher bits are ignored (aliasing permitted).
REQ-009 SHALL write byte lane i (data[8i+7:8i]) on acceptance when write_enable[i]=1; other lanes keep their contents.
REQ-010 SHALL, for an accepted request with read_enable=1, return exactly one result holding the full 32-bit word; no byte alignment or sign extension (the load path performs it).
REQ-011 SHALL produce no result for requests with read_enable=0 (stores, no-ops).
REQ-012 SHALL be read-first: when read_enable and write_enable are set in the same request, the result holds the pre-write word.
REQ-013 SHALL make a write visible to any read accepted in a later cycle (back-to-back store->load to the same word returns the new data).
REQ-014 SHALL read memory synchronously with 1-cycle latency; the read word enters the result buffer at the end of the cycle after acceptance.
REQ-015 SHALL assert mem_result.valid starting the second cycle after acceptance when the buffer was empty (accept in N -> valid in N+2).
REQ-016 SHALL return results in acceptance order.
REQ-017 SHALL hold mem_result.data stable while mem_result.valid=1 and mem_result.ready=0.
REQ-018 SHALL drive mem_request.ready from registered state only: ready = (inflight + count) < RESULT_DEPTH, where inflight is 1 if a read was accepted in the previous cycle and count is buffer occupancy; it has no combinational path from mem_result.ready.
REQ-019 SHALL sustain one accepted read per cycle indefinitely while mem_result.ready=1.
REQ-020 SHALL support simultaneous push (from the RAM stage) and pop (mem_result handshake) in one cycle, leaving count unchanged.
REQ-021 SHALL never overflow the buffer; by REQ-018 a full buffer plus in-flight read deasserts ready.
REQ-022 SHALL gate writes with ready: stores stall when ready=0, even though they produce no result.

Reset
REQ-023 SHALL, in any cycle with rst=0, clear inflight, buffer pointers and count; mem_result.valid=0 and mem_request.ready=0 in the following cycle while rst stays low.
REQ-024 SHALL discard in-flight reads and buffered results on reset mid-operation; no stale result appears after reset.
REQ-025 SHALL NOT clear memory contents on reset.
REQ-026 SHALL assert mem_request.ready=1 in the first cycle after rst returns high.

Structure
REQ-027 SHALL take GECKO_MEM_RESULT_DEPTH (default 3) and the byte-lane count constant from the gecko package.
REQ-028 SHALL instantiate std_fifo (WIDTH=32, DEPTH=RESULT_DEPTH) as the result buffer; memory array and inflight flag are local.

Verification
REQ-029 Write 0xDEADBEEF at addr 0x10 mask 4'b1111, then read 0x10 -> one result 0xDEADBEEF, valid two cycles after read acceptance.
REQ-030 Word 0x11223344 at 0x20; write data 0xAABBCCDD mask 4'b0101 to addr 0x22 -> read 0x20 returns 0x11BB33DD.
REQ-031 Word 0x00000005 at 0x30; single request read+write 0x00000009 -> result 0x00000005; next read -> 0x00000009.
REQ-032 Hold mem_result.ready=0, issue continuous reads of 0x0,0x4,0x8,0xC -> ready drops after three accepts, data held stable; release ready -> results in order, fourth accepted, none lost.
REQ-033 100 back-to-back reads with mem_result.ready=1 -> ready never drops, one result per cycle after two-cycle fill.
REQ-034 Two reads accepted, rst=0 for one cycle -> no results after reset, ready=1 the cycle after release, previously written data still readable.
